// File: rtl/mem_pkg.sv
// Shared node-memory geometry and arbiter state encodings.
package mem_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 11;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle around the node-memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = mem_pkg::WORD_WIDTH
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [WORD_WIDTH-1:0]         rdata;
  logic [ADDR_WIDTH-1:0]         mem_address;
  logic                          mem_wr_en;
  logic [WORD_WIDTH-1:0]         mem_data_in;
  logic [WORD_WIDTH-1:0]         mem_data_out;

  // Requesters plus the memory instance.
  modport master (
    output req, req_wr, req_addr, req_wdata, mem_data_out,
    input  gnt, rvalid, rdata, mem_address, mem_wr_en, mem_data_in
  );

  // The arbiter itself.
  modport slave (
    input  req, req_wr, req_addr, req_wdata, mem_data_out,
    output gnt, rvalid, rdata, mem_address, mem_wr_en, mem_data_in
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && req[j] && (PW'(j) == idx)) begin
          winner[j] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, burst-bounded arbiter for the single-port node memory.
// Optional contention counter on stat_wait when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = mem_pkg::WORD_WIDTH,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic          clock,
  input  logic          nrst,
  mem_arbiter_if.slave  bus,
  output logic [15:0]   stat_wait
);

  import mem_pkg::*;

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;

  logic [NUM_REQ-1:0]    pick_req, pick_win, others;
  logic [PW-1:0]         pick_ptr, pick_idx, next_ptr;
  logic                  pick_valid;
  logic                  own_req, own_wr, access, release_own;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [WORD_WIDTH-1:0] own_wdata;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    own_req   = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_win[k]) pick_idx = PW'(k);
      if (PW'(k) == owner_q) begin
        own_req   = bus.req[k];
        own_wr    = bus.req_wr[k];
        own_addr  = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = bus.req_wdata[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    next_ptr = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    access   = (state_q == ARB_OWN) && own_req;
    others   = bus.req & ~gnt_q;
  end

  // On release the picker is reused in the same cycle (pointer at owner+1,
  // owner masked out) so the next grant lands without an idle bubble.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rvalid_d    = '0;
    release_own = 1'b0;
    pick_req    = bus.req;
    pick_ptr    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_OWN;
          owner_d = pick_idx;
          gnt_d   = pick_win;
          burst_d = '0;
        end
      end
      ARB_OWN: begin
        addr_d   = own_addr;
        wdata_d  = own_wdata;
        pick_req = others;
        pick_ptr = next_ptr;
        if (!own_req) begin
          release_own = 1'b1;
        end else begin
          rvalid_d = gnt_q & {NUM_REQ{~own_wr}};
          if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
          if ((burst_q >= BW'(MAX_BURST - 1)) && (|others)) release_own = 1'b1;
        end
        if (release_own) begin
          rr_d    = next_ptr;
          burst_d = '0;
          if (pick_valid) begin
            owner_d = pick_idx;
            gnt_d   = pick_win;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      burst_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      burst_q  <= burst_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = (|rvalid_q) ? bus.mem_data_out : '0;
  assign bus.mem_address = (state_q == ARB_OWN) ? own_addr  : addr_q;
  assign bus.mem_data_in = (state_q == ARB_OWN) ? own_wdata : wdata_q;
  assign bus.mem_wr_en   = access & own_wr;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if ((|(bus.req & ~gnt_q)) && (stat_q != '1)) stat_d = stat_q + 1'b1;
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_wait = stat_q;
`else
  assign stat_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural 2048x16 memory.
module tb_mem_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 11;
  localparam int unsigned WW = 16;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [10:0] a0, a1, a2;
    logic [15:0] wd;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic        we;
    logic [10:0] maddr;
    logic        chk_rd;
    logic [15:0] rd;
  } vec_t;

  logic        clock, nrst, load;
  logic [15:0] stat_wait;
  logic [15:0] mem [0:2047];
  int          checks, errors, tally;
  vec_t        vecs [23];

  mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_BURST(8)) dut (
    .clock     (clock),
    .nrst      (nrst),
    .bus       (bus),
    .stat_wait (stat_wait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] memf(input logic [10:0] a);
    return 16'h599C ^ {5'b0, a};
  endfunction

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= memf(11'(i));
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end
    bus.mem_data_out <= mem[bus.mem_address];
  end

  function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [2:0] wr,
                              input logic [10:0] a0, input logic [10:0] a1, input logic [10:0] a2,
                              input logic [15:0] wd, input logic [2:0] gnt, input logic [2:0] rv,
                              input logic we, input logic [10:0] maddr, input logic chk_rd,
                              input logic [15:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd;
    v.gnt = gnt; v.rv = rv; v.we = we; v.maddr = maddr; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [10:0] a0,
                       input logic [10:0] a1, input logic [10:0] a2, input logic [15:0] wd);
    bus.req       = r;
    bus.req_wr    = w;
    bus.req_addr  = {a2, a1, a0};
    bus.req_wdata = {wd, wd, wd};
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(3'b000, 3'b000, '0, '0, '0, '0);
    repeat (2) @(negedge clock);
    nrst  = 1'b1;
    tally = 0;
  endtask

  initial begin
    logic [10:0] a;
    int          acc;
    checks = 0; errors = 0; tally = 0;
    load = 1'b1;
    nrst = 1'b0;
    drive(3'b000, 3'b000, '0, '0, '0, '0);

    #2;
    check("rst_gnt",    32'(bus.gnt),         0);
    check("rst_rvalid", 32'(bus.rvalid),      0);
    check("rst_rdata",  32'(bus.rdata),       0);
    check("rst_wr_en",  32'(bus.mem_wr_en),   0);
    check("rst_addr",   32'(bus.mem_address), 0);
    check("rst_din",    32'(bus.mem_data_in), 0);
    check("rst_stat",   32'(stat_wait),       0);
    @(negedge clock);
    load = 1'b0;
    @(negedge clock);
    nrst = 1'b1;

    // single read, write then readback (requester 1)
    vecs[0]  = mk(0, 3'b001, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b000, 3'b000, 0, 11'h000, 0, 16'h0);
    vecs[1]  = mk(0, 3'b001, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b001, 3'b000, 0, 11'h005, 0, 16'h0);
    vecs[2]  = mk(0, 3'b000, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b001, 3'b001, 0, 11'h005, 1, 16'h5999);
    vecs[3]  = mk(0, 3'b000, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b000, 3'b000, 0, 11'h005, 0, 16'h0);
    vecs[4]  = mk(0, 3'b010, 3'b010, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b000, 3'b000, 0, 11'h005, 0, 16'h0);
    vecs[5]  = mk(0, 3'b010, 3'b010, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b010, 3'b000, 1, 11'h7FF, 0, 16'h0);
    vecs[6]  = mk(0, 3'b000, 3'b010, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b010, 3'b000, 0, 11'h7FF, 0, 16'h0);
    vecs[7]  = mk(0, 3'b010, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b000, 3'b000, 0, 11'h7FF, 0, 16'h0);
    vecs[8]  = mk(0, 3'b010, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b010, 3'b000, 0, 11'h7FF, 0, 16'h0);
    vecs[9]  = mk(0, 3'b000, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b010, 3'b010, 0, 11'h7FF, 1, 16'h04C4);
    vecs[10] = mk(0, 3'b000, 3'b000, 11'h005, 11'h7FF, 11'h000, 16'h04C4, 3'b000, 3'b000, 0, 11'h7FF, 0, 16'h0);
    // contention after reset: order 0,1,2 then next round from 0
    vecs[11] = mk(1, 3'b111, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b000, 3'b000, 0, 11'h000, 0, 16'h0);
    vecs[12] = mk(0, 3'b111, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b001, 3'b000, 0, 11'h010, 0, 16'h0);
    vecs[13] = mk(0, 3'b110, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b001, 3'b001, 0, 11'h010, 1, 16'h598C);
    vecs[14] = mk(0, 3'b110, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b010, 3'b000, 0, 11'h020, 0, 16'h0);
    vecs[15] = mk(0, 3'b100, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b010, 3'b010, 0, 11'h020, 1, 16'h59BC);
    vecs[16] = mk(0, 3'b100, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b100, 3'b000, 0, 11'h030, 0, 16'h0);
    vecs[17] = mk(0, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b100, 3'b100, 0, 11'h030, 1, 16'h59AC);
    vecs[18] = mk(0, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b000, 3'b000, 0, 11'h030, 0, 16'h0);
    vecs[19] = mk(0, 3'b111, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b000, 3'b000, 0, 11'h030, 0, 16'h0);
    vecs[20] = mk(0, 3'b111, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b001, 3'b000, 0, 11'h010, 0, 16'h0);
    vecs[21] = mk(0, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b001, 3'b001, 0, 11'h010, 1, 16'h598C);
    vecs[22] = mk(0, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 3'b000, 3'b000, 0, 11'h010, 0, 16'h0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else @(negedge clock);
      drive(vecs[i].req, vecs[i].wr, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].wd);
      #2;
      check($sformatf("v%0d_gnt", i),    32'(bus.gnt),         32'(vecs[i].gnt));
      check($sformatf("v%0d_rvalid", i), 32'(bus.rvalid),      32'(vecs[i].rv));
      check($sformatf("v%0d_wr_en", i),  32'(bus.mem_wr_en),   32'(vecs[i].we));
      check($sformatf("v%0d_addr", i),   32'(bus.mem_address), 32'(vecs[i].maddr));
      if (vecs[i].we)     check($sformatf("v%0d_din", i),   32'(bus.mem_data_in), 32'(vecs[i].wd));
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), 32'(bus.rdata),       32'(vecs[i].rd));
      check($sformatf("v%0d_stat", i), 32'(stat_wait), STATS ? 32'(tally) : 0);
      if (|(vecs[i].req & ~vecs[i].gnt)) tally++;
    end

    // burst limit: requester 0 streams, requester 2 joins at cycle 3
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clock);
      a = 11'h100 + 11'((c == 0) ? 0 : ((c <= 8) ? c - 1 : 8));
      drive({(c >= 3 && c <= 9), 1'b0, 1'b1}, 3'b000, a, 11'h000, 11'h200, 16'h0);
      #2;
      check($sformatf("b8_c%0d_gnt", c), 32'(bus.gnt),
            (c == 0) ? 0 : ((c <= 8) ? 32'b001 : 32'b100));
      if (c >= 1 && c <= 8) check($sformatf("b8_c%0d_addr", c), 32'(bus.mem_address), 32'(a));
      if (c >= 2 && c <= 9) begin
        check($sformatf("b8_c%0d_rvalid", c), 32'(bus.rvalid), 32'b001);
        check($sformatf("b8_c%0d_rdata", c),  32'(bus.rdata),  32'(memf(11'h100 + 11'(c - 2))));
      end
      if (c == 10) begin
        check("b8_c10_rvalid", 32'(bus.rvalid), 32'b100);
        check("b8_c10_rdata",  32'(bus.rdata),  32'(memf(11'h200)));
      end
    end
    @(negedge clock);
    drive(3'b000, 3'b000, '0, '0, '0, '0);
    repeat (2) @(negedge clock);

    // requester 0 alone: all 20 accesses uninterrupted
    do_reset();
    acc = 0;
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) @(negedge clock);
      a = 11'h300 + 11'((c == 0) ? 0 : c - 1);
      drive({2'b00, (c <= 20)}, 3'b000, a, 11'h000, 11'h000, 16'h0);
      #2;
      check($sformatf("b20_c%0d_gnt", c), 32'(bus.gnt), (c == 0) ? 0 : 32'b001);
      if (c >= 2) begin
        check($sformatf("b20_c%0d_rvalid", c), 32'(bus.rvalid), 32'b001);
        check($sformatf("b20_c%0d_rdata", c),  32'(bus.rdata),  32'(memf(11'h300 + 11'(c - 2))));
      end
      if (bus.gnt[0] && bus.req[0]) acc++;
    end
    check("b20_accesses", 32'(acc), 20);
    @(negedge clock);
    drive(3'b000, 3'b000, '0, '0, '0, '0);
    #2;
    check("b20_end_gnt", 32'(bus.gnt), 0);

    // reset during requester 1's read; pointer is 2 before the reset
    do_reset();
    drive(3'b010, 3'b000, 11'h000, 11'h040, 11'h000, 16'h0);
    repeat (2) @(negedge clock);
    drive(3'b000, 3'b000, 11'h000, 11'h040, 11'h000, 16'h0);
    #2;
    check("mr_first_rvalid", 32'(bus.rvalid), 32'b010);
    check("mr_first_rdata",  32'(bus.rdata),  32'(memf(11'h040)));
    @(negedge clock);
    drive(3'b010, 3'b000, 11'h000, 11'h041, 11'h000, 16'h0);
    repeat (2) @(negedge clock);
    #2;
    check("mr_pre_gnt",  32'(bus.gnt),         32'b010);
    check("mr_pre_addr", 32'(bus.mem_address), 32'h041);
    #1;
    nrst = 1'b0;
    drive(3'b000, 3'b000, '0, '0, '0, '0);
    #1;
    check("mr_async_gnt",   32'(bus.gnt),         0);
    check("mr_async_wr_en", 32'(bus.mem_wr_en),   0);
    check("mr_async_addr",  32'(bus.mem_address), 0);
    check("mr_async_stat",  32'(stat_wait),       0);
    nrst = 1'b1;
    @(negedge clock);
    drive(3'b111, 3'b000, 11'h050, 11'h051, 11'h052, 16'h0);
    #2;
    check("mr_discard_rvalid", 32'(bus.rvalid), 0);
    check("mr_idle_gnt",       32'(bus.gnt),    0);
    @(negedge clock);
    #2;
    check("mr_ptr_restart_gnt", 32'(bus.gnt), 32'b001);
    drive(3'b000, 3'b000, '0, '0, '0, '0);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
